// File: rtl/cpu_usm_pkg.sv
// Shared definitions for the cpu_usm_v1 design: RV32I opcode and function
// field codes, host command byte codes, state encodings for the command FSM
// and the UART receiver, the default bit period, and the ALU helper that the
// execute stage uses for both OP and OP-IMM instructions.
package cpu_usm_pkg;

    localparam int CLKS_PER_BIT = 100_000_000 / 115200;

    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;
    localparam logic [2:0] F3_WORD = 3'd2;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [7:0] CMD_LOAD   = 8'h00;
    localparam logic [7:0] CMD_REG_LO = 8'h01;
    localparam logic [7:0] CMD_REG_HI = 8'h1F;
    localparam logic [7:0] CMD_MEM_LO = 8'h80;
    localparam logic [7:0] CMD_MEM_HI = 8'hBF;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD0, ST_LOAD1, ST_LOAD2, ST_LOAD3, ST_EXEC, ST_SEND
    } cmd_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    // alt selects sub (with F3_ADD) or arithmetic right shift (with F3_SR).
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            F3_ADD:  r = alt ? a - b : a + b;
            F3_SLL:  r = a << b[4:0];
            F3_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            F3_SLTU: r = {31'b0, a < b};
            F3_XOR:  r = a ^ b;
            F3_SR:   r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            F3_OR:   r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_usm_top_uart.sv
// 8N1 UART receiver and transmitter sharing one bit-period parameter.
// Ports:
//   clk, reset (async, active-low), clear (sync, active-high: abort both
//   directions and drop any byte in flight), rx (raw serial in, synchronised
//   here), rx_data/rx_valid (one-cycle pulse at the stop-bit midpoint of a
//   correctly framed byte), tx_start/tx_data (accepted only while idle),
//   tx (serial out, idle high), tx_busy.
module uart_8n1 #(
    parameter int CLKS_PER_BIT = cpu_usm_pkg::CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy
);
    import cpu_usm_pkg::*;

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    // rx_sync[1] is the synchronised line; rx_sync[2] is its previous value
    logic [2:0]    rx_sync;
    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [9:0]    tx_shift;

    // Receiver: the start bit is re-checked at its midpoint so a glitch or the
    // tail of a mis-framed stop bit does not start a byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync  <= '1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[1:0], rx};
            rx_valid <= 1'b0;
            if (clear) begin
                rx_state <= RX_IDLE;
                rx_cnt   <= '0;
            end else begin
                case (rx_state)
                    RX_IDLE: if (rx_sync[2] && !rx_sync[1]) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                    RX_START: if (rx_cnt == HALF) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync[1] ? RX_IDLE : RX_DATA;
                    end else rx_cnt <= rx_cnt + 1'b1;
                    RX_DATA: if (rx_cnt == FULL) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync[1], rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else rx_cnt <= rx_cnt + 1'b1;
                    RX_STOP: if (rx_cnt == FULL) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync[1]) begin
                            rx_valid <= 1'b1;
                            rx_data  <= rx_shift;
                        end
                    end else rx_cnt <= rx_cnt + 1'b1;
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    // Transmitter: the frame is a 10-bit shift register refilled with ones,
    // so tx comes straight from a flop and idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_shift <= '1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_busy  <= 1'b0;
        end else if (clear) begin
            tx_shift <= '1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_busy  <= 1'b0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx_shift <= {1'b1, tx_data, 1'b0};
                tx_cnt   <= '0;
                tx_bit   <= '0;
                tx_busy  <= 1'b1;
            end
        end else if (tx_cnt == FULL) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b1, tx_shift[9:1]};
            if (tx_bit == 4'd9) tx_busy <= 1'b0;
            else tx_bit <= tx_bit + 1'b1;
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    assign tx = tx_shift[0];

endmodule

// File: rtl/cpu_usm_top.sv
// Chip-level top of cpu_usm_v1: a UART-driven RV32I-subset execution engine.
// The host streams instructions (0x00 + 4 bytes little-endian) that execute
// at once against a 32x32 register file and a word data memory, and reads
// registers (0x01-0x1F) or memory words (0x80-0xBF) back as 4 bytes LE.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low global reset
//   reset2 active-low core clear (synchronised here): clears state and memories
//   rx     UART receive, idle high
//   tx     UART transmit, idle high
module cpu_usm_top #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DMEM_WORDS = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic reset2,
    input  logic rx,
    output logic tx
);
    import cpu_usm_pkg::*;

    localparam int BIT_CLKS = CLK_HZ / BAUD;
    localparam int AW       = $clog2(DMEM_WORDS);

    logic [1:0]    reset2_sync;
    logic          core_clear;
    logic [7:0]    rx_data, tx_data;
    logic          rx_valid, tx_start, tx_busy, tx_start_q;
    logic          is_reg_cmd, is_mem_cmd;
    cmd_state_t    state, state_next;
    logic [31:0]   instr, send_word;
    logic [2:0]    send_cnt;
    logic [31:0]   regs [32];
    logic [31:0]   dmem [DMEM_WORDS];
    logic [6:0]    opcode, funct7;
    logic [2:0]    funct3;
    logic [4:0]    rd, rs1, rs2;
    logic [31:0]   rs1v, rs2v, imm_i, imm_s, mem_addr, wb_val;
    logic [AW-1:0] mem_idx;
    logic          wb_en, mem_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) reset2_sync <= 2'b00;
        else        reset2_sync <= {reset2_sync[0], reset2};
    end
    assign core_clear = !reset2_sync[1];

    uart_8n1 #(.CLKS_PER_BIT(BIT_CLKS)) u_uart (
        .clk(clk), .reset(reset), .clear(core_clear), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_start(tx_start), .tx_data(tx_data), .tx(tx), .tx_busy(tx_busy)
    );

    assign is_reg_cmd = (rx_data >= CMD_REG_LO) && (rx_data <= CMD_REG_HI);
    assign is_mem_cmd = (rx_data >= CMD_MEM_LO) && (rx_data <= CMD_MEM_HI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          state <= ST_IDLE;
        else if (core_clear) state <= ST_IDLE;
        else                 state <= state_next;
    end

    // tx_busy rises one cycle after tx_start, so tx_start_q blocks a second
    // start in that gap. SEND ends only once the fourth byte has left the line.
    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        case (state)
            ST_IDLE: if (rx_valid) begin
                if (rx_data == CMD_LOAD)         state_next = ST_LOAD0;
                else if (is_reg_cmd || is_mem_cmd) state_next = ST_SEND;
            end
            ST_LOAD0: if (rx_valid) state_next = ST_LOAD1;
            ST_LOAD1: if (rx_valid) state_next = ST_LOAD2;
            ST_LOAD2: if (rx_valid) state_next = ST_LOAD3;
            ST_LOAD3: if (rx_valid) state_next = ST_EXEC;
            ST_EXEC:  state_next = ST_IDLE;
            ST_SEND: begin
                tx_start = !tx_busy && !tx_start_q && (send_cnt != 3'd4);
                if (send_cnt == 3'd4 && !tx_busy && !tx_start_q) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign tx_data = send_word[{send_cnt[1:0], 3'b000} +: 8];

    // Instruction bytes shift in from the top so the first byte ends up as the
    // least significant; the read-back word is latched when the command lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || core_clear) begin
            instr      <= '0;
            send_word  <= '0;
            send_cnt   <= '0;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= tx_start;
            if (tx_start) send_cnt <= send_cnt + 1'b1;
            if (rx_valid && state inside {ST_LOAD0, ST_LOAD1, ST_LOAD2, ST_LOAD3})
                instr <= {rx_data, instr[31:8]};
            if (rx_valid && state == ST_IDLE) begin
                send_cnt <= '0;
                if (is_reg_cmd)      send_word <= regs[rx_data[4:0]];
                else if (is_mem_cmd) send_word <= dmem[rx_data[AW-1:0]];
            end
        end
    end

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign funct7   = instr[31:25];
    assign rs1v     = regs[rs1];
    assign rs2v     = regs[rs2];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign mem_addr = rs1v + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign mem_idx  = AW'(mem_addr >> 2);

    // Decode: any encoding outside the supported subset leaves wb_en and
    // mem_we low and therefore behaves as a no-op.
    always_comb begin
        wb_en  = 1'b0;
        wb_val = '0;
        mem_we = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                wb_val = alu(funct3, (funct3 == F3_SR) && (funct7 == F7_ALT), rs1v, imm_i);
                if (funct3 == F3_SLL)     wb_en = (funct7 == F7_BASE);
                else if (funct3 == F3_SR) wb_en = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                else                      wb_en = 1'b1;
            end
            OPC_OP: begin
                wb_val = alu(funct3, funct7 == F7_ALT, rs1v, rs2v);
                wb_en  = (funct7 == F7_BASE) ||
                         ((funct7 == F7_ALT) && (funct3 == F3_ADD || funct3 == F3_SR));
            end
            OPC_LUI: begin
                wb_en  = 1'b1;
                wb_val = {instr[31:12], 12'h000};
            end
            OPC_LOAD: begin
                wb_en  = (funct3 == F3_WORD);
                wb_val = dmem[mem_idx];
            end
            OPC_STORE: mem_we = (funct3 == F3_WORD);
            default: ;
        endcase
    end

    // x0 is never written, so it stays at its cleared value of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || core_clear) begin
            for (int i = 0; i < 32; i++)         regs[i] <= '0;
            for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
        end else if (state == ST_EXEC) begin
            if (wb_en && rd != 5'd0) regs[rd] <= wb_val;
            if (mem_we)              dmem[mem_idx] <= rs2v;
        end
    end

endmodule

// File: tb/tb_cpu_usm_top.sv
// Testbench for cpu_usm_top: drives serial frames on rx, decodes tx with an
// independent UART monitor, and compares read-backs against directed constants
// and an instruction-level reference model of the register file and memory.
module tb_cpu_usm_top;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset, reset2, rx;
    logic tx;

    int errors = 0;
    int checks = 0;
    bit monitorOn = 1'b0;
    logic [7:0] txBytes[$];

    logic [31:0] mRegs [32];
    logic [31:0] mMem [64];
    int storedIdx[$];

    cpu_usm_top #(.CLK_HZ(1_600_000), .BAUD(100_000), .DMEM_WORDS(64)) dut (
        .clk(clk), .reset(reset), .reset2(reset2), .rx(rx), .tx(tx)
    );

    always #5ns clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Serial frame onto rx; badStop drives the stop bit low.
    task automatic applyStimulus(input logic [7:0] data, input bit badStop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (CPB) @(negedge clk);
        end
        rx = !badStop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Reference model: executes one instruction by the RV32I rules.
    function automatic logic [31:0] sra(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = v >> n;
        if (v[31]) r = r | ~(32'hFFFF_FFFF >> n);
        return r;
    endfunction

    function automatic void modelExec(input logic [31:0] ins);
        logic [31:0] a, b, immI, immS, res;
        logic [6:0] op, f7;
        logic [2:0] f3;
        int sh, idx, rd;
        bit wr;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; rd = int'(ins[11:7]);
        a = mRegs[ins[19:15]]; b = mRegs[ins[24:20]];
        immI = {{20{ins[31]}}, ins[31:20]};
        immS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        wr = 1'b0; res = '0;
        if (op == 7'h13) begin
            sh = int'(ins[24:20]);
            wr = 1'b1;
            case (f3)
                3'd0: res = a + immI;
                3'd2: res = ($signed(a) < $signed(immI)) ? 32'd1 : 32'd0;
                3'd3: res = (a < immI) ? 32'd1 : 32'd0;
                3'd4: res = a ^ immI;
                3'd6: res = a | immI;
                3'd7: res = a & immI;
                3'd1: begin wr = (f7 == 7'h00); res = a << sh; end
                default: begin
                    if (f7 == 7'h00)      res = a >> sh;
                    else if (f7 == 7'h20) res = sra(a, sh);
                    else                  wr = 1'b0;
                end
            endcase
        end else if (op == 7'h33) begin
            sh = int'(b[4:0]);
            if (f7 == 7'h00) begin
                wr = 1'b1;
                case (f3)
                    3'd0: res = a + b;
                    3'd1: res = a << sh;
                    3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: res = (a < b) ? 32'd1 : 32'd0;
                    3'd4: res = a ^ b;
                    3'd5: res = a >> sh;
                    3'd6: res = a | b;
                    default: res = a & b;
                endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                wr = 1'b1; res = a - b;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                wr = 1'b1; res = sra(a, sh);
            end
        end else if (op == 7'h37) begin
            wr = 1'b1; res = {ins[31:12], 12'h000};
        end else if (op == 7'h03 && f3 == 3'd2) begin
            idx = int'(((a + immI) >> 2) % 64);
            wr = 1'b1; res = mMem[idx];
        end else if (op == 7'h23 && f3 == 3'd2) begin
            idx = int'(((a + immS) >> 2) % 64);
            mMem[idx] = b;
            storedIdx.push_back(idx);
        end
        if (wr && rd != 0) mRegs[rd] = res;
    endfunction

    function automatic void modelClear();
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
        for (int i = 0; i < 64; i++) mMem[i] = '0;
        storedIdx.delete();
    endfunction

    function automatic logic [6:0] pickF7();
        case ($urandom_range(0, 3))
            0, 1:    return 7'h00;
            2:       return 7'h20;
            default: return 7'h01;
        endcase
    endfunction

    function automatic logic [31:0] randInstr();
        logic [31:0] ins;
        ins = $urandom;
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0, 1, 2: begin
                ins[6:0] = 7'h13;
                ins[24:20] = 5'($urandom);
                if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ins[31:25] = pickF7();
            end
            3, 4: begin ins[6:0] = 7'h33; ins[31:25] = pickF7(); end
            5:    ins[6:0] = 7'h37;
            6:    begin ins[6:0] = 7'h03; ins[14:12] = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'd2; end
            7, 8: begin ins[6:0] = 7'h23; ins[14:12] = 3'd2; end
            default: ins = $urandom;
        endcase
        return ins;
    endfunction

    task automatic loadInstr(input logic [31:0] ins);
        applyStimulus(8'h00, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(ins[8*k +: 8], 1'b0);
        modelExec(ins);
    endtask

    task automatic readWord(input logic [7:0] cmd, input logic [31:0] exp, input string tag);
        logic [31:0] word;
        txBytes.delete();
        applyStimulus(cmd, 1'b0);
        for (int t = 0; t < CPB * 60 && txBytes.size() < 4; t++) @(negedge clk);
        if (txBytes.size() < 4) begin
            checkOutput({tag, "_timeout"}, 32'(txBytes.size()), 32'd4);
        end else begin
            word = {txBytes[3], txBytes[2], txBytes[1], txBytes[0]};
            checkOutput(tag, word, exp);
        end
        repeat (CPB) @(negedge clk);
    endtask

    task automatic expectNoTx(input string tag);
        repeat (12 * CPB) @(negedge clk);
        checkOutput(tag, 32'(txBytes.size()), 32'd0);
    endtask

    // Serial monitor on tx, sampling at bit midpoints.
    initial begin
        logic [7:0] b;
        wait (monitorOn);
        forever begin
            @(negedge tx);
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            checkOutput("txStop", {31'b0, tx}, 32'd1);
            txBytes.push_back(b);
        end
    end

    initial begin
        reset = 1'b0; reset2 = 1'b0; rx = 1'b1;
        modelClear();
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("resetTx", {31'b0, tx}, 32'd1);
        repeat (100) @(negedge clk);
        reset2 = 1'b1;
        repeat (10) @(negedge clk);
        monitorOn = 1'b1;
        @(negedge clk);

        $display("[TB] reset state");
        readWord(8'h01, 32'h0, "resetX1");
        readWord(8'h80, 32'h0, "resetMem0");

        $display("[TB] test 1: addi and register read");
        loadInstr(32'h0050_0113);
        readWord(8'h02, 32'h5, "t1X2");

        $display("[TB] test 2: sub");
        loadInstr(32'h00C0_0193);
        loadInstr(32'h0090_0813);
        loadInstr(32'h4101_83B3);
        readWord(8'h03, 32'hC, "t2X3");
        readWord(8'h10, 32'h9, "t2X16");
        readWord(8'h07, 32'h3, "t2X7");

        $display("[TB] test 3: or and sw");
        loadInstr(32'h0023_E233);
        loadInstr(32'h0041_A023);
        readWord(8'h04, 32'h7, "t3X4");
        readWord(8'h83, 32'h7, "t3Mem3");

        $display("[TB] test 4: x0 behaviour and underflow");
        loadInstr(32'h0050_0013);
        loadInstr(32'h0000_02B3);
        readWord(8'h05, 32'h0, "t4X5");
        loadInstr(32'h4030_0333);
        readWord(8'h06, 32'hFFFF_FFF4, "t4X6");

        $display("[TB] test 5: bad stop bits");
        txBytes.delete();
        applyStimulus(8'h02, 1'b1);
        expectNoTx("t5NoTx");
        readWord(8'h02, 32'h5, "t5X2");
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h13, 1'b0);
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h04, 1'b0);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h07, 1'b0);
        modelExec(32'h07F0_0413);
        readWord(8'h08, 32'h7F, "t5X8");

        $display("[TB] ignored command bytes");
        txBytes.delete();
        applyStimulus(8'h40, 1'b0);
        applyStimulus(8'hC5, 1'b0);
        applyStimulus(8'h20, 1'b0);
        expectNoTx("ignoredNoTx");
        readWord(8'h03, 32'hC, "ignoredX3");

        $display("[TB] test 6: core clear mid load");
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h93, 1'b0);
        applyStimulus(8'h00, 1'b0);
        reset2 = 1'b0;
        repeat (40) @(negedge clk);
        reset2 = 1'b1;
        modelClear();
        repeat (10) @(negedge clk);
        readWord(8'h02, 32'h0, "t6X2Clear");
        readWord(8'h83, 32'h0, "t6Mem3Clear");
        loadInstr(32'h0050_0113);
        readWord(8'h02, 32'h5, "t6X2New");

        $display("[TB] randomized instructions");
        for (int n = 0; n < 16; n++) loadInstr(randInstr());
        for (int r = 1; r < 8; r++)
            readWord(8'(r), mRegs[r], $sformatf("randX%0d", r));
        for (int k = 0; k < 4 && k < storedIdx.size(); k++)
            readWord(8'h80 | 8'(storedIdx[storedIdx.size() - 1 - k]),
                     mMem[storedIdx[storedIdx.size() - 1 - k]],
                     $sformatf("randMem%0d", storedIdx[storedIdx.size() - 1 - k]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
